// File: rtl/alu_pkg.sv
// Shared types for the binary-op ALU sequencer.
// Unit codes, operand width and FSM state encoding.
package alu_pkg;

  localparam int ALU_W = 16;

  typedef logic [3:0] alu_unit_t;

  localparam alu_unit_t ALU_OR = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_STROBE,
    ST_RESP
  } binop_seq_state_t;

endpackage

// File: rtl/alu_binop_sequencer_if.sv
// Request/response handshake bundle of the sequencer.
// master = microcode side, slave = sequencer.
interface alu_binop_sequencer_if;
  import alu_pkg::*;

  logic             req_valid;
  logic             req_ready;
  alu_unit_t        req_op;
  logic [ALU_W-1:0] req_a;
  logic [ALU_W-1:0] req_b;
  logic             req_fl;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [ALU_W-1:0] rsp_y;
  logic             rsp_v;
  logic             rsp_fltadd;
  logic             busy;

  modport master (
    output req_valid, req_op, req_a,
    output req_b, req_fl, rsp_ready,
    input  req_ready, rsp_valid, rsp_y,
    input  rsp_v, rsp_fltadd, busy
  );

  modport slave (
    input  req_valid, req_op, req_a,
    input  req_b, req_fl, rsp_ready,
    output req_ready, rsp_valid, rsp_y,
    output rsp_v, rsp_fltadd, busy
  );

endinterface

// File: rtl/alu_seq_timer.sv
// Loadable down-counter with zero flag.
// Shared between the settle and strobe phases.
module alu_seq_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] val,
  output logic         zero
);

  logic [W-1:0] cnt;

  // load wins over decrement; saturate at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/alu_binop_sequencer.sv
// Initiator for the binary-op ALU: holds operands,
// strobes the output enable and returns the result.
module alu_binop_sequencer
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int NBOE_CYCLES   = 1
) (
  input  logic                 clk3,
  input  logic                 nreset,
  alu_binop_sequencer_if.slave bus,
  output logic [ALU_W-1:0]     alu_ac,
  output logic [ALU_W-1:0]     alu_b,
  output alu_unit_t            alu_runit,
  output logic                 alu_fl,
  output logic                 alu_nboe,
  input  logic [ALU_W-1:0]     alu_y,
  input  logic                 alu_fv,
  input  logic                 alu_nfltadd
);

  localparam int MAXC =
    (SETTLE_CYCLES > NBOE_CYCLES) ?
    SETTLE_CYCLES : NBOE_CYCLES;
  localparam int TW = $clog2(MAXC + 1);

  localparam logic [TW-1:0] SET_LD =
    TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] NB_LD =
    TW'(NBOE_CYCLES - 1);

  binop_seq_state_t state;
  binop_seq_state_t nxt;

  logic          accept;
  logic          capture;
  logic          t_load;
  logic          t_dec;
  logic          t_zero;
  logic [TW-1:0] t_val;

  assign accept  = bus.req_valid & bus.req_ready;
  assign capture = (state == ST_STROBE) & t_zero;

  alu_seq_timer #(
    .W (TW)
  ) u_timer (
    .clk   (clk3),
    .rst_n (nreset),
    .load  (t_load),
    .dec   (t_dec),
    .val   (t_val),
    .zero  (t_zero)
  );

  // state register
  always_ff @(posedge clk3 or negedge nreset) begin
    if (!nreset) begin
      state <= ST_IDLE;
    end else begin
      state <= nxt;
    end
  end

  // next-state logic
  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE:   if (accept) nxt = ST_SETTLE;
      ST_SETTLE: if (t_zero) nxt = ST_STROBE;
      ST_STROBE: if (t_zero) nxt = ST_RESP;
      ST_RESP:   if (bus.rsp_ready) nxt = ST_IDLE;
      default:   nxt = ST_IDLE;
    endcase
  end

  // state decodes: handshake status and timer control
  always_comb begin
    bus.req_ready = 1'b0;
    bus.busy      = 1'b1;
    t_load        = 1'b0;
    t_dec         = 1'b0;
    t_val         = NB_LD;
    unique case (1'b1)
      state == ST_IDLE: begin
        bus.req_ready = 1'b1;
        bus.busy      = 1'b0;
        t_load        = accept;
        t_val         = SET_LD;
      end
      state == ST_SETTLE: begin
        t_load = t_zero;
        t_dec  = 1'b1;
      end
      state == ST_STROBE: begin
        t_dec = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // registered strobe, response and operand latches
  always_ff @(posedge clk3 or negedge nreset) begin
    if (!nreset) begin
      alu_nboe       <= 1'b1;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_y      <= '0;
      bus.rsp_v      <= 1'b0;
      bus.rsp_fltadd <= 1'b0;
      alu_ac         <= '0;
      alu_b          <= '0;
      alu_runit      <= '0;
      alu_fl         <= 1'b0;
    end else begin
      alu_nboe      <= (nxt != ST_STROBE);
      bus.rsp_valid <= (nxt == ST_RESP);
      if (accept) begin
        alu_ac    <= bus.req_a;
        alu_b     <= bus.req_b;
        alu_runit <= bus.req_op;
        alu_fl    <= bus.req_fl;
      end
      if (capture) begin
        bus.rsp_y      <= alu_y;
        bus.rsp_v      <= alu_fv;
        bus.rsp_fltadd <= ~alu_nfltadd;
      end
    end
  end

endmodule
